// File: rtl/uart_rx_if.sv
// Serial line in, recovered byte and status pulses out, for uart_byte_rx.
// The slave modport is the receiver; the master modport is the line source / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  modport master (
    output rx,
    input  rx_msg, rx_complete, rx_frame_err, rx_parity_err, rx_busy
  );

  modport slave (
    input  rx,
    output rx_msg, rx_complete, rx_frame_err, rx_parity_err, rx_busy
  );
endinterface

// File: rtl/uart_byte_rx.sv
// Oversampling UART byte receiver (8N1 at CLKS_PER_BIT clocks per bit).
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop (8E1).
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 27,
  parameter int SYNC_STAGES  = 2
) (
  input  logic     clk_3125KHz,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam logic [4:0] BIT_LAST  = 5'(CLKS_PER_BIT - 1);
  localparam logic [4:0] HALF_LAST = 5'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   rxs;

  state_t     state;
  logic [4:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic [7:0] msg_q;
  logic       complete_q;
  logic       frame_err_q;
  logic       busy_q;
  logic       par_fail;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err_q;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  assign par_fail          = par_bad;
  assign bus.rx_parity_err = parity_err_q;
`else
  assign par_fail          = 1'b0;
  assign bus.rx_parity_err = 1'b0;
`endif

  // ---- input synchroniser: line idles high, so reset to all ones ----
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) sync_p0 <= '1;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.rx};
  end

  assign rxs = sync_p0[SYNC_STAGES-1];

  // ---- frame FSM: all outputs registered, pulses default low ----
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      msg_q       <= '0;
      complete_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      complete_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rxs) begin
              busy_q  <= 1'b1;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 5'd1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 5'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_bad <= (rxs != even_par(shift_reg));
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 5'd1;
          end
        end
`endif

        // Leaving at mid stop bit lets an immediately following start bit be caught.
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rxs && !par_fail) begin
              msg_q      <= shift_reg;
              complete_q <= 1'b1;
            end
            frame_err_q <= !rxs;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= par_bad;
`endif
            if (rxs) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 5'd1;
          end
        end

        // A held-low line must not be decoded as a string of 0x00 bytes.
        BREAK: begin
          if (rxs) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_msg       = msg_q;
  assign bus.rx_complete  = complete_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised self-checking bench for uart_byte_rx against a frame-level event model.
// Build with +define+UART_RX_PARITY_EN to exercise the 8E1 variant.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int CPB = 27;
`ifdef UART_RX_PARITY_EN
  localparam int  FLEN   = 11;
  localparam bit  PAR_ON = 1'b1;
`else
  localparam int  FLEN   = 10;
  localparam bit  PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if u_if ();

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk_3125KHz (clk),
    .rst         (rst),
    .bus         (u_if)
  );

  always #160 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observed events: {complete, frame_err, parity_err, byte-if-complete}
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];
  int          comp_t[$];
  int          cyc        = 0;
  int          excl_bad   = 0;
  int          busy_bad   = 0;
  bit          busy_seen  = 1'b0;
  bit          prev_busy  = 1'b0;
  logic [7:0]  last_good  = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (u_if.rx_complete || u_if.rx_frame_err || u_if.rx_parity_err) begin
      obs_q.push_back({u_if.rx_complete, u_if.rx_frame_err, u_if.rx_parity_err,
                       u_if.rx_complete ? u_if.rx_msg : 8'h00});
      if (u_if.rx_complete) begin
        comp_t.push_back(cyc);
        if (u_if.rx_frame_err || u_if.rx_parity_err) excl_bad++;
        if (u_if.rx_busy || !prev_busy) busy_bad++;
      end
    end
    if (u_if.rx_busy) busy_seen = 1'b1;
    prev_busy = u_if.rx_busy;
  end

  // Line-level frame: start 0, data LSB first, optional even parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_ok,
                                           input logic stop);
    logic p;
    p = (^d) ^ ~par_ok;
    if (PAR_ON) return {stop, p, d, 1'b0};
    return {1'b0, stop, d, 1'b0};
  endfunction

  // What the receiver should report for one frame.
  function automatic logic [10:0] exp_evt(input logic [7:0] d, input logic par_ok,
                                          input logic stop);
    logic pbad;
    pbad = PAR_ON && !par_ok;
    if (stop && !pbad) return {3'b100, d};
    return {1'b0, !stop, pbad, 8'h00};
  endfunction

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      u_if.rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    u_if.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
    logic [10:0] e;
    e = exp_evt(d, par_ok, stop);
    exp_q.push_back(e);
    if (e[10]) last_good = d;
    send_raw(mk_frame(d, par_ok, stop), FLEN);
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".evt"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, ".msg"}, 32'(u_if.rx_msg), 32'(last_good));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".msg"},  32'(u_if.rx_msg), 32'h0);
    chk({tag, ".cmp"},  32'(u_if.rx_complete), 32'h0);
    chk({tag, ".ferr"}, 32'(u_if.rx_frame_err), 32'h0);
    chk({tag, ".perr"}, 32'(u_if.rx_parity_err), 32'h0);
    chk({tag, ".busy"}, 32'(u_if.rx_busy), 32'h0);
  endtask

  logic [7:0] ifm [8] = '{8'h49, 8'h46, 8'h4D, 8'h2D, 8'h45, 8'h55, 8'h2D, 8'h23};

  initial begin
    logic [7:0] d;
    logic       stop, par_ok;
    logic [10:0] fr;

    // Reset state
    u_if.rx = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(5);

    // 1: single good byte
    send_frame(8'h49, 1'b1, 1'b1);
    idle(CPB);
    compare_events("t1");

    // 2: short glitch is a false start
    busy_seen = 1'b0;
    u_if.rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * CPB);
    chk("t2.busy", 32'(busy_seen), 32'h0);
    compare_events("t2");

    // 3: framing error, long break, then recovery
    send_frame(8'h46, 1'b1, 1'b0);
    u_if.rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    chk("t3.hold", 32'(obs_q.size()), 32'h1);
    chk("t3.keep", 32'(u_if.rx_msg), 32'(last_good));
    idle(2 * CPB);
    send_frame(8'h4D, 1'b1, 1'b1);
    idle(CPB);
    compare_events("t3");

    // 4: back-to-back message, no idle between frames
    comp_t.delete();
    for (int i = 0; i < 8; i++) send_frame(ifm[i], 1'b1, 1'b1);
    idle(CPB);
    for (int i = 1; i < comp_t.size(); i++)
      chk("t4.gap", 32'((comp_t[i] - comp_t[i-1] >= FLEN * CPB - 1) &&
                        (comp_t[i] - comp_t[i-1] <= FLEN * CPB + 1)), 32'h1);
    compare_events("t4");

    // 5: reset in the middle of bit 4 of 0x50
    fr = mk_frame(8'h50, 1'b1, 1'b1);
    send_raw(fr, 5);
    u_if.rx = fr[5];
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("t5.rst");
    u_if.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle(2 * CPB);
    compare_events("t5.abort");
    send_frame(8'h42, 1'b1, 1'b1);
    idle(CPB);
    compare_events("t5");

`ifdef UART_RX_PARITY_EN
    // 6: wrong then correct parity on 0x53
    send_frame(8'h53, 1'b0, 1'b1);
    idle(CPB);
    compare_events("t6.bad");
    send_frame(8'h53, 1'b1, 1'b1);
    idle(CPB);
    compare_events("t6.good");
`endif

    // Randomised frames with occasional stop/parity errors and random gaps
    for (int n = 0; n < 24; n++) begin
      d      = 8'($urandom);
      stop   = ($urandom_range(0, 7) != 0);
      par_ok = ($urandom_range(0, 5) != 0);
      send_frame(d, par_ok, stop);
      if (!stop) idle(CPB + $urandom_range(0, 20));
      else       idle($urandom_range(0, 40));
    end
    idle(CPB);
    compare_events("rand");

    chk("excl", 32'(excl_bad), 32'h0);
    chk("busy_fall", 32'(busy_bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial-to-parallel UART receiver that sits directly upstream of the message parser.
- Oversamples the RX line on the 3.125 MHz system clock and recovers 8N1 frames at 115200 baud.
- For each good frame it presents one byte on rx_msg and pulses rx_complete for exactly one cycle.
- The downstream parser assembles those bytes into "IFM-xx-#" / "PBM-SU-Bn-#" messages.

Parameters:
- CLKS_PER_BIT, 27, clock cycles per bit period (3125000/115200, truncated).
- SYNC_STAGES, 2, number of flip-flops in the RX input synchroniser (minimum 2).

Ports:
- clk_3125KHz  input  1  system clock, 3.125 MHz.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  raw serial line; idles high.
- rx_msg  output  8  last good received byte; holds until the next good frame.
- rx_complete  output  1  one-cycle pulse when rx_msg has just been updated.
- rx_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- rx_parity_err  output  1  one-cycle pulse on parity mismatch (tied 0 when the optional feature is off).
- rx_busy  output  1  high from start-bit confirmation until the FSM returns to IDLE.

Behaviour:
- Reset: asynchronous and active-high. It forces state=IDLE and clears counters and the shift register.
  - Synchroniser flops are set to 1 (line idle).
  - Outputs reset to rx_msg=8'h00, rx_complete=0, rx_frame_err=0, rx_parity_err=0, rx_busy=0.
  - A reset mid-frame discards the partial byte with no pulse.
- Input path: rx passes through SYNC_STAGES flops. All decisions use the synchronised value rxs, so latency from line to FSM is SYNC_STAGES cycles.
- Bit counter clk_cnt is 5 bits wide. bit_idx is 3 bits wide and covers data bits 0..7.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
  - IDLE: when rxs==0, clear clk_cnt and go to START.
  - START: count to CLKS_PER_BIT/2-1 (=12), which is mid start bit.
    - If rxs==0 there: rx_busy=1, clk_cnt=0, bit_idx=0, go to DATA.
    - If rxs==1 there: false start; return to IDLE with no output.
  - DATA: at clk_cnt==CLKS_PER_BIT-1, sample rxs into shift_reg[bit_idx] (LSB first) and clear clk_cnt. After bit_idx==7, go to PARITY if enabled, otherwise STOP. bit_idx does not wrap within a frame.
  - PARITY: sample at clk_cnt==CLKS_PER_BIT-1 (see Optional Feature), then go to STOP.
  - STOP: sample at clk_cnt==CLKS_PER_BIT-1.
    - rxs==1: rx_msg<=shift_reg and rx_complete=1 on the next cycle, for one cycle. Go to IDLE with rx_busy=0.
    - rxs==0: rx_frame_err=1 for one cycle, rx_msg unchanged, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE with rx_busy=0. This prevents a held-low line from being re-decoded as a stream of 0x00 bytes.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start bit that immediately follows the stop bit is caught with no gap required.
- Simultaneous events: a parity error and a frame error in the same frame give both pulses, and rx_msg is not updated. rx_complete and any error pulse are never high together.
- Throughput: at most one rx_complete per 10 bit periods (11 with parity). The downstream stage must register rx_msg on rx_complete; there is no backpressure.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is included and a 9th bit (even parity) is expected between data and stop.
  - Mismatch gives rx_parity_err=1 for one cycle, coincident with STOP resolution, and rx_msg is not updated.
  - Frame length is 11 bits.
- Undefined:
  - The PARITY state and its logic are not compiled.
  - rx_parity_err is tied 0.
  - Frame is 8N1.

Test Plan:
1. Reset, then send 0x49 at 27 clk/bit → exactly one rx_complete pulse, rx_msg=8'h49, rx_frame_err=0, rx_busy falls on the same cycle as the pulse.
2. Drive rx low for 5 cycles, then high → no rx_complete, no error, rx_busy stays 0, FSM back in IDLE.
3. Send 0x46 with stop bit 0, then hold rx low for 40 bit times, then high; then send 0x4D → one rx_frame_err pulse, rx_msg keeps its previous value, no pulses during the hold; then rx_complete with rx_msg=8'h4D.
4. Send "IFM-EU-#" (0x49,0x46,0x4D,0x2D,0x45,0x55,0x2D,0x23) back-to-back with zero idle → 8 rx_complete pulses, 270 cycles apart ±1, bytes in order.
5. Assert rst during bit 4 of 0x50, release, then send 0x42 → no pulse for the aborted frame; rx_msg=8'h42 after the next frame; all outputs read 0 while in reset.
6. (UART_RX_PARITY_EN) Send 0x53 with parity bit 1 (wrong; 0x53 has four 1s) → rx_parity_err pulse, rx_msg unchanged. Resend with parity 0 → rx_complete, rx_msg=8'h53.
